// File: rtl/pwm_pkg.sv
// Shared types and default sizes for the PWM channel slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

  // Default width of the counter high slice and of the duty registers.
  localparam int PWM_WIDTH_DEF      = 8;
  // Default width of the dead-time cycle count.
  localparam int PWM_DEAD_WIDTH_DEF = 4;

  // Channel control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_channel_if.sv
// Channel bus: counter value, enable, duty handshake, dead time and PWM outputs.
// Latency: n/a (wires only).
// Backpressure: duty_ready_o low while the pending duty slot is occupied.
interface pwm_channel_if
  import pwm_pkg::*;
#(
  parameter int WIDTH      = PWM_WIDTH_DEF,
  parameter int DEAD_WIDTH = PWM_DEAD_WIDTH_DEF
) ();

  logic [WIDTH-1:0]      value_i;
  logic                  enable_i;
  logic [WIDTH-1:0]      duty_i;
  logic                  duty_valid_i;
  logic                  duty_ready_o;
  logic [DEAD_WIDTH-1:0] dead_i;
  logic                  pwm_o;
  logic                  pwm_n_o;
  logic                  wrap_o;

  // Driver side: counter, controller and duty producer.
  modport master (
    output value_i,
    output enable_i,
    output duty_i,
    output duty_valid_i,
    output dead_i,
    input  duty_ready_o,
    input  pwm_o,
    input  pwm_n_o,
    input  wrap_o
  );

  // Channel side.
  modport slave (
    input  value_i,
    input  enable_i,
    input  duty_i,
    input  duty_valid_i,
    input  dead_i,
    output duty_ready_o,
    output pwm_o,
    output pwm_n_o,
    output wrap_o
  );

endinterface

// File: rtl/pwm_deadtime.sv
// Dead-time inserter (built only with PWM_DEADTIME_EN): both outputs low for dead_i cycles after each raw edge.
// Latency: 1 cycle from raw to outputs when no dead interval is running; dead_i extra cycles after an edge.
// Backpressure: none; dead_i is sampled at the start of each dead interval.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DEAD_WIDTH = PWM_DEAD_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  raw,
  input  logic                  run,
  input  logic [DEAD_WIDTH-1:0] dead_i,
  output logic                  pwm_o,
  output logic                  pwm_n_o
);

  logic                  side_q, side_d;
  logic [DEAD_WIDTH-1:0] cnt_q, cnt_d;
  logic                  pwm_q, pwm_d;
  logic                  pwm_n_q, pwm_n_d;

  // Track the side raw is on; an edge starts (or restarts) a dead interval toward the new side.
  always_comb begin
    side_d  = side_q;
    cnt_d   = cnt_q;
    pwm_d   = 1'b0;
    pwm_n_d = 1'b0;
    if (!run) begin
      // Outside RUN the side follows raw so entering RUN does not fake an edge.
      side_d = raw;
      cnt_d  = '0;
    end else if (raw != side_q) begin
      side_d = raw;
      if (dead_i == '0) begin
        cnt_d   = '0;
        pwm_d   = raw;
        pwm_n_d = ~raw;
      end else begin
        cnt_d = dead_i;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DEAD_WIDTH'(1);
      // Last dead cycle: the new side is driven on the following edge.
      if (cnt_q == DEAD_WIDTH'(1)) begin
        pwm_d   = side_q;
        pwm_n_d = ~side_q;
      end
    end else begin
      pwm_d   = side_q;
      pwm_n_d = ~side_q;
    end
  end

  // Dead-time state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      side_q  <= 1'b0;
      cnt_q   <= '0;
      pwm_q   <= 1'b0;
      pwm_n_q <= 1'b0;
    end else begin
      side_q  <= side_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_d;
      pwm_n_q <= pwm_n_d;
    end
  end

  assign pwm_o   = pwm_q;
  assign pwm_n_o = pwm_n_q;

endmodule

// File: rtl/pwm_channel.sv
// PWM channel: compares the counter high slice against a double-buffered duty; optional dead time via PWM_DEADTIME_EN.
// Latency: 1 cycle from value_i to pwm_o/pwm_n_o/wrap_o; a new duty takes effect at the next detected wrap.
// Backpressure: duty_ready_o drops the cycle after an accept and rises the cycle after the wrap that consumes it.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH      = PWM_WIDTH_DEF,
  parameter int DEAD_WIDTH = PWM_DEAD_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  pwm_channel_if.slave bus
);

  pwm_state_e       state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0] duty_q, duty_d;

  logic             wrap;
  logic             accept;
  logic [WIDTH-1:0] duty_eff;
  logic             raw;
  logic             run;
  logic             pwm_out;
  logic             pwm_n_out;

  // A drop in the monotonic counter value marks the start of a new period.
  assign wrap   = bus.value_i < value_q;
  assign accept = bus.duty_valid_i && !pend_vld_q;

  // On the wrap cycle the compare already uses the duty that governs the
  // period being started, so the first count of that period is not judged
  // against the previous period's threshold.
  assign duty_eff = (wrap && pend_vld_q) ? pend_q : duty_q;
  assign raw      = bus.value_i < duty_eff;

  // Wrap tracking and the pending/active duty double buffer.
  always_comb begin
    value_d    = bus.value_i;
    wrap_d     = wrap;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    duty_d     = duty_q;
    if (wrap && pend_vld_q) begin
      duty_d     = pend_q;
      pend_vld_d = 1'b0;
    end else if (accept) begin
      // An accept on a wrap cycle (slot was empty) waits for the next wrap.
      pend_d     = bus.duty_i;
      pend_vld_d = 1'b1;
    end
  end

  // Channel FSM next state; disable wins from any state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable_i) state_d = ARMED;
      end
      ARMED: begin
        // Start at a wrap, or on a fresh start where the counter sits at zero.
        if (wrap || (bus.value_i == '0 && value_q == '0)) state_d = RUN;
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!bus.enable_i) state_d = IDLE;
  end

  // Outputs are registered alongside the state, so gate with the next state.
  assign run = (state_d == RUN);

  // Control and duty registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      value_q    <= '0;
      wrap_q     <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      duty_q     <= '0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      wrap_q     <= wrap_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      duty_q     <= duty_d;
    end
  end

`ifdef PWM_DEADTIME_EN
  pwm_deadtime #(
    .DEAD_WIDTH (DEAD_WIDTH)
  ) u_deadtime (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw     (raw),
    .run     (run),
    .dead_i  (bus.dead_i),
    .pwm_o   (pwm_out),
    .pwm_n_o (pwm_n_out)
  );
`else
  logic                  pwm_q, pwm_d;
  logic                  pwm_n_q, pwm_n_d;
  logic [DEAD_WIDTH-1:0] dead_unused;

  // Dead time is not built in this configuration.
  assign dead_unused = bus.dead_i;

  // Plain complementary outputs while running, both low otherwise.
  always_comb begin
    pwm_d   = 1'b0;
    pwm_n_d = 1'b0;
    if (run) begin
      pwm_d   = raw;
      pwm_n_d = ~raw;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_q   <= 1'b0;
      pwm_n_q <= 1'b0;
    end else begin
      pwm_q   <= pwm_d;
      pwm_n_q <= pwm_n_d;
    end
  end

  assign pwm_out   = pwm_q;
  assign pwm_n_out = pwm_n_q;
`endif

  assign bus.duty_ready_o = ~pend_vld_q;
  assign bus.wrap_o       = wrap_q;
  assign bus.pwm_o        = pwm_out;
  assign bus.pwm_n_o      = pwm_n_out;

endmodule

// File: tb/tb_pwm_channel.sv
// Directed bench for pwm_channel: reset, arming, duty double buffering, handshake and enable control.
// Latency: outputs sampled 1 ns after the edge that registers them.
// Backpressure: duty loads are single-cycle valid pulses; loads while the slot is full are expected to be dropped.
`timescale 1ns/1ps
module tb_pwm_channel;

  localparam int W  = 8;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pwm_channel_if #(.WIDTH(W), .DEAD_WIDTH(DW)) pif ();

  pwm_channel #(
    .WIDTH      (W),
    .DEAD_WIDTH (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (pif.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present a counter value, then step to 1 ns past the edge that registers it.
  task automatic tick(input int v);
    pif.value_i = 8'(v);
    @(posedge clk);
    #1;
  endtask

  // Plain complementary expectation in RUN at threshold d.
  task automatic check_plain(input int v, input int d);
    check_val($sformatf("pwm v=%0d d=%0d", v, d), 32'(pif.pwm_o), 32'(v < d));
    check_val($sformatf("pwm_n v=%0d d=%0d", v, d), 32'(pif.pwm_n_o), 32'(!(v < d)));
  endtask

  // One full period 0..255 in RUN at threshold d with optional duty loads.
  task automatic sweep(input int d, input int rdy0, input int load_at, input int load_val,
                       input int load2_val);
    for (int v = 0; v < 256; v++) begin
      if (v == load_at) begin
        pif.duty_valid_i = 1'b1;
        pif.duty_i       = 8'(load_val);
      end else if (v == load_at + 1 && load2_val >= 0) begin
        pif.duty_valid_i = 1'b1;
        pif.duty_i       = 8'(load2_val);
      end
      tick(v);
      pif.duty_valid_i = 1'b0;
      check_plain(v, d);
      check_val($sformatf("wrap_o v=%0d d=%0d", v, d), 32'(pif.wrap_o), 32'(v == 0));
      if (v == 0) check_val($sformatf("rdy_at_wrap d=%0d", d), 32'(pif.duty_ready_o), 32'(rdy0));
      if (v == load_at) check_val($sformatf("rdy_after_load %0d", load_val), 32'(pif.duty_ready_o), 0);
      if (v == load_at + 1 && load2_val >= 0)
        check_val("rdy_still_full", 32'(pif.duty_ready_o), 0);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    pif.value_i      = '0;
    pif.enable_i     = 1'b0;
    pif.duty_i       = '0;
    pif.duty_valid_i = 1'b0;
    pif.dead_i       = '0;
    repeat (3) tick(0);
    check_val("rst_ready", 32'(pif.duty_ready_o), 1);
    check_val("rst_pwm", 32'(pif.pwm_o), 0);
    check_val("rst_pwm_n", 32'(pif.pwm_n_o), 0);
    check_val("rst_wrap", 32'(pif.wrap_o), 0);

    // Preload duty 64 while disabled.
    rst_n            = 1'b1;
    pif.duty_i       = 8'd64;
    pif.duty_valid_i = 1'b1;
    tick(0);
    pif.duty_valid_i = 1'b0;
    check_val("rdy_preload", 32'(pif.duty_ready_o), 0);

    // First period after enable: armed, outputs low, no wrap.
    pif.enable_i = 1'b1;
    for (int v = 0; v < 256; v++) begin
      tick(v);
      check_val($sformatf("armed_pwm v=%0d", v), 32'(pif.pwm_o), 0);
      check_val($sformatf("armed_pwm_n v=%0d", v), 32'(pif.pwm_n_o), 0);
      check_val($sformatf("armed_wrap v=%0d", v), 32'(pif.wrap_o), 0);
    end
    check_val("rdy_armed_end", 32'(pif.duty_ready_o), 0);

    // Running at 64.
    sweep(64, 1, -1, 0, -1);
    // Load 192 mid-period: 64 holds until the wrap.
    sweep(64, 1, 128, 192, -1);
    check_val("rdy_held_to_wrap", 32'(pif.duty_ready_o), 0);
    sweep(192, 1, 10, 0, -1);
    // Duty 0: never high.
    sweep(0, 1, 5, 255, -1);
    // Duty 255: low only at 255; back-to-back load, 10 dropped.
    sweep(255, 1, 20, 100, 10);
    sweep(100, 1, -1, 0, -1);
    // Accept on the wrap cycle: 50 waits a full period.
    sweep(100, 0, 0, 50, -1);

    // Period at 50, disabled mid-run, re-enabled (armed until wrap); load 64.
    for (int v = 0; v < 256; v++) begin
      if (v == 30) pif.enable_i = 1'b0;
      if (v == 100) pif.enable_i = 1'b1;
      if (v == 150) begin
        pif.duty_valid_i = 1'b1;
        pif.duty_i       = 8'd64;
        pif.dead_i       = 4'd3;
      end
      tick(v);
      pif.duty_valid_i = 1'b0;
      if (v == 0) check_val("rdy_50_active", 32'(pif.duty_ready_o), 1);
      if (v < 30) begin
        check_plain(v, 50);
      end else begin
        check_val($sformatf("off_pwm v=%0d", v), 32'(pif.pwm_o), 0);
        check_val($sformatf("off_pwm_n v=%0d", v), 32'(pif.pwm_n_o), 0);
      end
    end

    // Two periods at 64 after re-arming.
    for (int p = 0; p < 2; p++) begin
      for (int v = 0; v < 256; v++) begin
        tick(v);
`ifdef PWM_DEADTIME_EN
        check_val($sformatf("dt_pwm v=%0d", v), 32'(pif.pwm_o), 32'(v >= 3 && v < 64));
        check_val($sformatf("dt_pwm_n v=%0d", v), 32'(pif.pwm_n_o), 32'(v >= 67));
        check_val($sformatf("dt_overlap v=%0d", v), 32'(pif.pwm_o & pif.pwm_n_o), 0);
`else
        check_plain(v, 64);
`endif
        check_val($sformatf("wrap_o p=%0d v=%0d", p, v), 32'(pif.wrap_o), 32'(v == 0));
      end
    end

    // Reset mid-period drops an in-flight duty.
    pif.duty_valid_i = 1'b1;
    pif.duty_i       = 8'd77;
    tick(0);
    pif.duty_valid_i = 1'b0;
    check_val("rdy_before_rst", 32'(pif.duty_ready_o), 0);
    rst_n = 1'b0;
    tick(1);
    check_val("midrst_ready", 32'(pif.duty_ready_o), 1);
    check_val("midrst_pwm", 32'(pif.pwm_o), 0);
    check_val("midrst_pwm_n", 32'(pif.pwm_n_o), 0);
    check_val("midrst_wrap", 32'(pif.wrap_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
